// File: rtl/o_user_encoder_emu_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package o_user_encoder_emu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b1;  // A leads B, position counts up
  localparam logic DIR_REV = 1'b0;  // B leads A, position counts down

  localparam int STEP_W_DEF   = 24;
  localparam int PERIOD_W_DEF = 20;
  localparam int POS_W_DEF    = 32;

  // Gray sequence over one quadrature cycle, returned as {A, B}.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    logic [1:0] ab;
    case (phase)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/o_user_encoder_emu_if.sv
// Command and encoder-output bundle between a move issuer and the emulator.
// Latency: n/a (wires only).
// Backpressure: cmd_vld/cmd_rdy handshake; cmd_rdy low while a move runs.
// Signals: cmd_vld/cmd_rdy/cmd_steps/cmd_dir/cmd_period and abort from the
// master; enc_a/enc_b/enc_z, busy, done and signed pos from the emulator.
interface o_user_encoder_emu_if
  import o_user_encoder_emu_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int POS_W    = POS_W_DEF
);
  logic                cmd_vld;
  logic                cmd_rdy;
  logic [STEP_W-1:0]   cmd_steps;
  logic                cmd_dir;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic                enc_a;
  logic                enc_b;
  logic                enc_z;
  logic                busy;
  logic                done;
  logic [POS_W-1:0]    pos;

  modport master (
    output cmd_vld, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_rdy, enc_a, enc_b, enc_z, busy, done, pos
  );

  modport slave (
    input  cmd_vld, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_rdy, enc_a, enc_b, enc_z, busy, done, pos
  );
endinterface

// File: rtl/o_user_encoder_emu_step_timer.sv
// Edge-rate divider: loadable down-counter that ticks once every `period` clocks.
// Latency: tick is combinational from the count register (count == 1).
// Backpressure: none; counts only while en is high, clear/rst force it to 0.
// Ports: clk, rst, clear, load + load_val (first interval), en, period
// (reload interval), tick.
module o_user_encoder_emu_step_timer #(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt;

  assign tick = en && (cnt == PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == PERIOD_W'(1)) ? period : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/o_user_encoder_emu.sv
// Quadrature encoder emulator: emits Gray-coded A/B, Z index and a signed position per move command.
// Latency: first edge visible period clocks after the accept cycle (period 1 => with BUSY rise).
// Backpressure: cmd_rdy only in IDLE (also the DONE cycle of the last edge); abort ends a move.
// Ports: clk, rst (synchronous, active-high), bus (slave side of o_user_encoder_emu_if).
module o_user_encoder_emu
  import o_user_encoder_emu_pkg::*;
#(
  parameter int CPR      = 4096,
  parameter int Z_INDEX  = 2,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int POS_W    = POS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  o_user_encoder_emu_if.slave   bus
);
  localparam int            RW      = $clog2(CPR);
  localparam logic [RW-1:0] REV_MAX = RW'(CPR - 1);
  localparam logic [RW-1:0] Z_POS   = RW'(Z_INDEX);

  state_t              state;
  logic [RW-1:0]       rev_pos;
  logic [STEP_W-1:0]   remaining;
  logic                dir_q;
  logic [PERIOD_W-1:0] period_q;
  logic                enc_a_q, enc_b_q, enc_z_q, busy_q, done_q, rdy_q;
  logic [POS_W-1:0]    pos_q;

  logic                accept, step_dir, do_step, tick, run_step, last_step;
  logic                steps_zero, period_one;
  logic [PERIOD_W-1:0] p_eff, load_val;
  logic [RW-1:0]       next_rev;
  logic [POS_W-1:0]    next_pos;

  assign bus.cmd_rdy = rdy_q;
  assign bus.enc_a   = enc_a_q;
  assign bus.enc_b   = enc_b_q;
  assign bus.enc_z   = enc_z_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pos     = pos_q;

  always_comb begin
    accept     = (state == IDLE) && bus.cmd_vld;
    steps_zero = (bus.cmd_steps == '0);
    p_eff      = (bus.cmd_period == '0) ? PERIOD_W'(1) : bus.cmd_period;
    period_one = (p_eff == PERIOD_W'(1));
    // With period 1 the first edge lands on the accept edge itself, so the
    // timer starts one interval ahead; otherwise it covers period-1 clocks.
    load_val   = period_one ? PERIOD_W'(1) : p_eff - 1'b1;
    run_step   = (state == RUN) && !bus.abort && tick;
    last_step  = run_step && (remaining == STEP_W'(1));
    do_step    = run_step || (accept && !steps_zero && period_one);
    step_dir   = (state == IDLE) ? bus.cmd_dir : dir_q;
    if (step_dir == DIR_FWD) begin
      next_rev = (rev_pos == REV_MAX) ? '0 : rev_pos + 1'b1;
      next_pos = pos_q + 1'b1;
    end else begin
      next_rev = (rev_pos == '0) ? REV_MAX : rev_pos - 1'b1;
      next_pos = pos_q - 1'b1;
    end
  end

  o_user_encoder_emu_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == RUN) && (bus.abort || last_step)),
    .load     (accept && !steps_zero),
    .load_val (load_val),
    .en       (state == RUN),
    .period   (period_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rev_pos   <= '0;
      remaining <= '0;
      dir_q     <= DIR_FWD;
      period_q  <= PERIOD_W'(1);
      enc_a_q   <= 1'b0;
      enc_b_q   <= 1'b0;
      enc_z_q   <= 1'b0;
      pos_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (do_step) begin
        rev_pos            <= next_rev;
        {enc_a_q, enc_b_q} <= phase_to_ab(next_rev[1:0]);
        enc_z_q            <= (next_rev == Z_POS);
        pos_q              <= next_pos;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q    <= bus.cmd_dir;
            period_q <= p_eff;
            if (steps_zero || (period_one && bus.cmd_steps == STEP_W'(1))) begin
              done_q <= 1'b1;  // nothing left to run after this cycle
            end else begin
              state     <= RUN;
              busy_q    <= 1'b1;
              rdy_q     <= 1'b0;
              remaining <= period_one ? bus.cmd_steps - 1'b1 : bus.cmd_steps;
            end
          end
        end
        RUN: begin
          if (bus.abort || last_step) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (run_step) begin
            remaining <= remaining - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_o_user_encoder_emu.sv
// Scoreboard bench for o_user_encoder_emu with CPR=16: directed moves push expected
// A/B/Z/position/DONE events with their cycle; a negedge monitor pops on every A/B change or DONE.
module tb_o_user_encoder_emu;
  import o_user_encoder_emu_pkg::*;

  typedef struct {
    int          cyc;
    logic        a, b, z, done;
    logic [31:0] pos;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   in_reset = 1'b1;
  logic [1:0] prev_ab = 2'b00;
  ev_t  exp_q[$];

  int          m_rev = 0;
  logic [31:0] m_pos = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  o_user_encoder_emu_if #(.STEP_W(24), .PERIOD_W(20), .POS_W(32)) bus ();

  o_user_encoder_emu #(
    .CPR(16), .Z_INDEX(2), .STEP_W(24), .PERIOD_W(20), .POS_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Quadrature table written out by hand: phase -> {A,B}.
  function automatic logic [1:0] ab_ref(input int rev);
    case (rev % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic push_state(input int c, input logic dn);
    logic [1:0] ab;
    ab = ab_ref(m_rev);
    exp_q.push_back('{c, ab[1], ab[0], (m_rev == 2), dn, m_pos});
  endtask

  task automatic push_step(input int c, input bit dir, input logic dn);
    if (dir) begin
      m_rev = (m_rev == 15) ? 0 : m_rev + 1;
      m_pos = m_pos + 32'd1;
    end else begin
      m_rev = (m_rev == 0) ? 15 : m_rev - 1;
      m_pos = m_pos - 32'd1;
    end
    push_state(c, dn);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got 0x%0h need 0x%0h", name, act, req);
    end
  endtask

  // abort_edge>0: the move is aborted in the cycle that would apply that edge.
  // cut>0: only edges within cut clocks of acceptance are expected (reset follows).
  task automatic send(input int steps, input bit dir, input int per, input bit hold,
                      input int abort_edge, input int cut, output int t);
    int n;
    int p;
    int edges;
    n = 0;
    bus.cmd_vld    = 1'b1;
    bus.cmd_steps  = 24'(steps);
    bus.cmd_dir    = dir;
    bus.cmd_period = 20'(per);
    while (bus.cmd_rdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got rdy=%b need 1", bus.cmd_rdy);
      bus.cmd_vld = 1'b0;
      t = 0;
      return;
    end
    t = cyc;
    p = (per == 0) ? 1 : per;
    if (steps == 0) begin
      push_state(t + 1, 1'b1);
    end else begin
      edges = (abort_edge > 0) ? abort_edge - 1 : steps;
      for (int i = 1; i <= edges; i++) begin
        if (cut > 0 && p * i > cut) break;
        push_step(t + p * i, dir, (abort_edge == 0 && cut == 0 && i == steps));
      end
      if (abort_edge > 0) push_state(t + p * abort_edge, 1'b1);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.cmd_vld = 1'b0;
      bus.abort   = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending need 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_a"},     32'(bus.enc_a),   32'd0);
    chk({name, "_b"},     32'(bus.enc_b),   32'd0);
    chk({name, "_z"},     32'(bus.enc_z),   32'd0);
    chk({name, "_pos"},   bus.pos,          32'd0);
    chk({name, "_rdy"},   32'(bus.cmd_rdy), 32'd1);
    chk({name, "_busy"},  32'(bus.busy),    32'd0);
    chk({name, "_done"},  32'(bus.done),    32'd0);
  endtask

  // Monitor: one event per A/B change or DONE pulse, matched in order.
  always @(negedge clk) begin
    ev_t e;
    if (!in_reset && !rst && ({bus.enc_a, bus.enc_b} != prev_ab || bus.done === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got cyc=%0d ab=%b%b done=%b pos=%0d need none",
                 cyc, bus.enc_a, bus.enc_b, bus.done, bus.pos);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || bus.enc_a !== e.a || bus.enc_b !== e.b || bus.enc_z !== e.z ||
            bus.done !== e.done || bus.pos !== e.pos) begin
          errors++;
          $display("FAIL event got cyc=%0d ab=%b%b z=%b done=%b pos=0x%0h need cyc=%0d ab=%b%b z=%b done=%b pos=0x%0h",
                   cyc, bus.enc_a, bus.enc_b, bus.enc_z, bus.done, bus.pos,
                   e.cyc, e.a, e.b, e.z, e.done, e.pos);
        end
      end
    end
    prev_ab = {bus.enc_a, bus.enc_b};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish need finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.cmd_vld    = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;

    // Reset state after idling.
    repeat (10) @(negedge clk);
    chk_reset_vals("reset");

    // Reverse 3 at period 1 from rev 0: AB 01,11,10; position -3.
    send(3, DIR_REV, 1, 1'b0, 0, 0, t);
    drain("rev3");
    chk("rev3_pos", bus.pos, 32'hFFFF_FFFD);
    chk("rev3_ab", 32'({bus.enc_a, bus.enc_b}), 32'b10);

    // Back to rev 0, then forward 8 at period 4.
    send(3, DIR_FWD, 1, 1'b0, 0, 0, t);
    drain("fwd3");
    chk("fwd3_pos", bus.pos, 32'd0);
    send(8, DIR_FWD, 4, 1'b0, 0, 0, t);
    drain("fwd8");
    chk("fwd8_pos", bus.pos, 32'd8);
    chk("fwd8_busy", 32'(bus.busy), 32'd0);

    // Abort in the cycle that would apply edge 5: 4 edges, DONE next clock.
    send(100, DIR_FWD, 10, 1'b0, 5, 0, t);
    while (cyc < t + 49) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    drain("abort");
    chk("abort_pos", bus.pos, 32'd12);
    chk("abort_ab", 32'({bus.enc_a, bus.enc_b}), 32'b00);
    chk("abort_rdy", 32'(bus.cmd_rdy), 32'd1);

    // Abort in IDLE together with a command: command still runs.
    bus.abort = 1'b1;
    send(2, DIR_REV, 2, 1'b0, 0, 0, t);
    drain("idle_abort");
    // Zero-step command: DONE only.
    send(0, DIR_FWD, 5, 1'b0, 0, 0, t);
    drain("zero");
    chk("zero_pos", bus.pos, 32'd10);

    // Back-to-back with VALID held; second command's fields visible during RUN.
    send(6, DIR_FWD, 2, 1'b1, 0, 0, t);
    send(4, DIR_REV, 3, 1'b0, 0, 0, t);
    drain("b2b");
    chk("b2b_pos", bus.pos, 32'd12);

    // Period 0 behaves as 1; crosses the rev wrap and the Z index.
    send(9, DIR_FWD, 0, 1'b0, 0, 0, t);
    drain("p0");
    chk("p0_pos", bus.pos, 32'd21);

    // Reset mid-move: edges at +3,+6,+9 then reset values, no DONE.
    send(20, DIR_FWD, 3, 1'b0, 0, 10, t);
    while (cyc < t + 10) @(negedge clk);
    in_reset = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(bus.done), 32'd0);
    end
    m_rev = 0;
    m_pos = '0;
    in_reset = 1'b0;
    drain("midrst");

    // Fresh move after reset starts from rev 0.
    send(2, DIR_FWD, 2, 1'b0, 0, 0, t);
    drain("post_rst");
    chk("post_rst_pos", bus.pos, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
